// File: rtl/seq_demux_4b_1to8.sv
// 1-to-8 demultiplexer for 4-bit words, valid/ready on every port, 2-entry FIFO per channel.
// Define SEQ_DEMUX_BYPASS_EN for a zero-latency path into an empty channel whose consumer is ready.
module seq_demux_4b_1to8 (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_val,
  output logic       in_rdy,
  input  logic [3:0] in_data,
  input  logic [2:0] in_sel,
  output logic [7:0] out_val,
  input  logic [7:0] out_rdy,
  output logic [3:0] out0,
  output logic [3:0] out1,
  output logic [3:0] out2,
  output logic [3:0] out3,
  output logic [3:0] out4,
  output logic [3:0] out5,
  output logic [3:0] out6,
  output logic [3:0] out7
);

  logic [1:0] cnt_q  [8];
  logic [1:0] cnt_d  [8];
  logic [3:0] head_q [8];
  logic [3:0] head_d [8];
  logic [3:0] tail_q [8];
  logic [3:0] tail_d [8];
  logic [7:0] enq;
  logic [7:0] deq;
  logic [7:0] bypass;
  logic [3:0] outWord [8];

  // Ready depends only on the addressed channel's occupancy, never on in_val or out_rdy.
  always_comb begin
    in_rdy = (cnt_q[in_sel] != 2'd2);
  end

  always_comb begin
    for (int i = 0; i < 8; i++) begin
`ifdef SEQ_DEMUX_BYPASS_EN
      bypass[i] = in_val && (in_sel == 3'(i)) && (cnt_q[i] == 2'd0) && out_rdy[i];
`else
      bypass[i] = 1'b0;
`endif
      enq[i]     = in_val && in_rdy && (in_sel == 3'(i)) && !bypass[i];
      deq[i]     = (cnt_q[i] != 2'd0) && out_rdy[i];
      out_val[i] = (cnt_q[i] != 2'd0) || bypass[i];
      outWord[i] = bypass[i] ? in_data : ((cnt_q[i] != 2'd0) ? head_q[i] : 4'h0);

      cnt_d[i]  = cnt_q[i];
      head_d[i] = head_q[i];
      tail_d[i] = tail_q[i];
      // The head slot always holds the oldest word; a dequeue shifts the tail forward.
      case ({enq[i], deq[i]})
        2'b10: begin
          if (cnt_q[i] == 2'd0) head_d[i] = in_data;
          else                  tail_d[i] = in_data;
          cnt_d[i] = cnt_q[i] + 2'd1;
        end
        2'b01: begin
          head_d[i] = tail_q[i];
          cnt_d[i]  = cnt_q[i] - 2'd1;
        end
        2'b11: begin
          if (cnt_q[i] == 2'd1) begin
            head_d[i] = in_data;
          end else begin
            head_d[i] = tail_q[i];
            tail_d[i] = in_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) cnt_q[i] <= 2'd0;
    end else begin
      for (int i = 0; i < 8; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Storage needs no reset: outputs are masked whenever the count is zero.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      head_q[i] <= head_d[i];
      tail_q[i] <= tail_d[i];
    end
  end

  assign out0 = outWord[0];
  assign out1 = outWord[1];
  assign out2 = outWord[2];
  assign out3 = outWord[3];
  assign out4 = outWord[4];
  assign out5 = outWord[5];
  assign out6 = outWord[6];
  assign out7 = outWord[7];

endmodule
